adat_frame_receiver: RTL

ADAT_FRAME_RECEIVER -- requirements
Module: adat_frame_receiver

---
 rtl/adat_frame_receiver.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/adat_frame_receiver.sv
// adat_frame_receiver: decodes an NRZI ADAT stream into eight 24-bit channels plus a 4-bit user nibble.
// Ports:
//   clk          system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   adat_in      raw NRZI ADAT stream, asynchronous to clk
//   audio_out    decoded channel samples, ch0 first in the frame
//   user_out     user bits taken from frame bits 244:241
//   frame_valid  one-clk pulse when audio_out/user_out update
//   frame_error  one-clk pulse on any decode error or timeout
//   locked       high after two consecutive good frames
module adat_frame_receiver #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int SAMPLE_RATE = 48000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adat_in,
    output logic [23:0] audio_out [0:7],
    output logic [3:0]  user_out,
    output logic        frame_valid,
    output logic        frame_error,
    output logic        locked
);
    localparam int CPB = CLK_FREQ / (SAMPLE_RATE * 256);
    // Wide enough for the saturated run plus the half-cell rounding term.
    localparam int RW = $clog2(17 * CPB + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(16 * CPB);
    localparam logic [RW-1:0] TIMEOUT = RW'(13 * CPB);
    localparam logic [RW-1:0] HALF    = RW'(CPB / 2);
    localparam logic [RW-1:0] CELL    = RW'(CPB);
    localparam logic [1:0] HUNT = 2'd0, RECEIVE = 2'd1, WAIT_SYNC = 2'd2;

    logic [2:0]    sync_q, sync_d;
    logic [RW-1:0] run_q, run_d;
    logic [1:0]    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [244:0]  sr_q, sr_d;
    logic [23:0]   audio_q [0:7];
    logic [23:0]   audio_d [0:7];
    logic [3:0]    user_q, user_d;
    logic          valid_q, valid_d, err_q, err_d, lock_q, lock_d, one_q, one_d;
    logic          edge_w, is_sync, is_data, frame_ok;
    logic [RW-1:0] k_w;
    logic [8:0]    sum_w;
    logic [244:0]  shift_w;
    logic [23:0]   dec_w [0:7];

    always_comb begin
        sync_d  = {sync_q[1:0], adat_in};
        edge_w  = sync_q[1] ^ sync_q[2];
        k_w     = (run_q + HALF) / CELL;
        is_sync = k_w == RW'(11);
        is_data = k_w >= RW'(1) && k_w <= RW'(5);
        sum_w   = 9'(cnt_q) + 9'(k_w);
        // A run of k cells is k-1 zeros then a one, so shifting left by k and setting bit 0 appends it.
        shift_w = (sr_q << k_w) | 245'd1;
        frame_ok = shift_w[240];
        for (int g = 0; g < 48; g++)
            frame_ok = frame_ok & shift_w[5*g];
        dec_w = '{default: '0};
        for (int n = 0; n < 8; n++)
            for (int j = 0; j < 6; j++)
                dec_w[n][4*j +: 4] = shift_w[211 - 30*n + 5*j +: 4];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        audio_d = audio_q;
        user_d  = user_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        run_d   = edge_w ? RW'(1) : (run_q == RUN_MAX ? run_q : run_q + RW'(1));
        if (edge_w) begin
            case (state_q)
                HUNT: begin
                    state_d = is_sync ? RECEIVE : HUNT;
                    cnt_d   = '0;
                end
                RECEIVE: begin
                    if (is_data) begin
                        sr_d  = shift_w;
                        cnt_d = sum_w[7:0];
                        if (sum_w == 9'd245) begin
                            valid_d = frame_ok;
                            err_d   = !frame_ok;
                            state_d = frame_ok ? WAIT_SYNC : HUNT;
                            audio_d = frame_ok ? dec_w : audio_q;
                            user_d  = frame_ok ? shift_w[244:241] : user_q;
                        end else if (sum_w > 9'd245) begin
                            err_d   = 1'b1;
                            state_d = HUNT;
                        end
                    end else begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = is_sync ? RECEIVE : HUNT;
                    end
                end
                WAIT_SYNC: begin
                    err_d   = !is_sync;
                    cnt_d   = '0;
                    state_d = is_sync ? RECEIVE : HUNT;
                end
                default: state_d = HUNT;
            endcase
        end else if (state_q != HUNT && run_q == TIMEOUT) begin
            err_d   = 1'b1;
            state_d = HUNT;
        end
        // one_q remembers a good frame since the last error; the next good frame locks.
        one_d  = err_d ? 1'b0 : (valid_d ? 1'b1 : one_q);
        lock_d = err_d ? 1'b0 : (valid_d && one_q ? 1'b1 : lock_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            run_q   <= '0;
            state_q <= HUNT;
            cnt_q   <= '0;
            sr_q    <= '0;
            audio_q <= '{default: '0};
            user_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            lock_q  <= 1'b0;
            one_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            run_q   <= run_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            audio_q <= audio_d;
            user_q  <= user_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            lock_q  <= lock_d;
            one_q   <= one_d;
        end
    end

    assign audio_out   = audio_q;
    assign user_out    = user_q;
    assign frame_valid = valid_q;
    assign frame_error = err_q;
    assign locked      = lock_q;
endmodule
